// File: rtl/operand_collector.sv
// operand_collector
//   Gathers NUM_OPS operand beats of DATA_W bits into one bundle and holds it
//   until the consumer takes it. A broadcast beat (in_bcast) fills every slot
//   not yet written, so a bundle can finish early. Completed bundles are
//   counted in a free-running, wrapping counter.
//
// Ports
//   clk         clock, all state changes on its rising edge
//   rst         asynchronous active-low reset
//   in_valid    operand beat offered
//   in_data     operand value (DATA_W)
//   in_bcast    beat fills all remaining slots (only meaningful with in_valid)
//   in_ready    block accepts a beat this cycle
//   flush       synchronous abort of the partial or held bundle
//   ops         bundle, slot k at [k*DATA_W +: DATA_W], straight from registers
//   out_valid   bundle complete and held
//   out_ready   consumer takes the bundle
//   fill_level  index of the next slot to write (IDX_W)
//   bundle_cnt  number of bundles delivered (CNT_W, wraps)
module operand_collector #(
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(NUM_OPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_bcast,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [NUM_OPS*DATA_W-1:0] ops,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          fill_level,
  output logic [CNT_W-1:0]          bundle_cnt
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            fill_q, fill_d;
  logic [NUM_OPS*DATA_W-1:0]   slots_q, slots_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        accept;

  // While FULL, a beat may only enter in the same cycle the held bundle
  // leaves, so readiness follows out_ready combinationally. Gating with rst
  // keeps the block from advertising readiness while held in reset.
  assign in_ready = rst & ((state_q == COLLECT) | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      fill_q  <= '0;
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    slots_d = slots_q;
    cnt_d   = cnt_q;

    if (flush) begin
      // Abort wins over everything, including a delivery in progress,
      // and is deliberately not counted as a delivered bundle.
      state_d = COLLECT;
      fill_d  = '0;
      slots_d = '0;
    end else if (state_q == COLLECT) begin
      if (accept) begin
        if (in_bcast) begin
          // Earlier slots keep their values; only the unwritten tail is filled.
          for (int k = 0; k < NUM_OPS; k++) begin
            if (k >= int'(fill_q)) slots_d[k*DATA_W +: DATA_W] = in_data;
          end
          fill_d  = '0;
          state_d = FULL;
        end else begin
          for (int k = 0; k < NUM_OPS; k++) begin
            if (k == int'(fill_q)) slots_d[k*DATA_W +: DATA_W] = in_data;
          end
          if (fill_q == LAST_IDX) begin
            fill_d  = '0;
            state_d = FULL;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
    end else if (out_ready) begin
      // Held bundle leaves; a beat arriving now starts the next bundle.
      cnt_d = cnt_q + 1'b1;
      if (accept && in_bcast) begin
        for (int k = 0; k < NUM_OPS; k++) begin
          slots_d[k*DATA_W +: DATA_W] = in_data;
        end
        fill_d  = '0;
        state_d = FULL;
      end else if (accept) begin
        slots_d[0 +: DATA_W] = in_data;
        fill_d  = IDX_W'(1);
        state_d = COLLECT;
      end else begin
        fill_d  = '0;
        state_d = COLLECT;
      end
    end
  end

  assign ops        = slots_q;
  assign out_valid  = (state_q == FULL);
  assign fill_level = fill_q;
  assign bundle_cnt = cnt_q;

endmodule

// File: tb/tb_operand_collector.sv
// Testbench for operand_collector: one 2-operand instance (4-bit bundle
// counter) and one 4-operand instance. Stimulus pushes expected bundles into
// per-instance queues; a monitor pops and compares on every delivery.
module tb_operand_collector;

  logic clk;
  logic rst;

  // 2-operand instance, CNT_W = 4
  logic        iv2, ib2, fl2, or2, ir2, v2;
  logic [15:0] id2;
  logic [31:0] ops2;
  logic [0:0]  fill2;
  logic [3:0]  cnt2;

  // 4-operand instance, CNT_W = 16
  logic        iv4, ib4, fl4, or4, ir4, v4;
  logic [15:0] id4;
  logic [63:0] ops4;
  logic [1:0]  fill4;
  logic [15:0] cnt4;

  logic [31:0] q2[$];
  logic [63:0] q4[$];

  int n_cmp  = 0;
  int n_fail = 0;

  operand_collector #(.DATA_W(16), .NUM_OPS(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_data(id2), .in_bcast(ib2), .in_ready(ir2),
    .flush(fl2), .ops(ops2), .out_valid(v2), .out_ready(or2),
    .fill_level(fill2), .bundle_cnt(cnt2)
  );

  operand_collector #(.DATA_W(16), .NUM_OPS(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_data(id4), .in_bcast(ib4), .in_ready(ir4),
    .flush(fl4), .ops(ops4), .out_valid(v4), .out_ready(or4),
    .fill_level(fill4), .bundle_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic [15:0] d, input logic b);
    iv2 = v; id2 = d; ib2 = b;
  endtask

  task automatic drive4(input logic v, input logic [15:0] d, input logic b);
    iv4 = v; id4 = d; ib4 = b;
  endtask

  // Delivery monitor: a bundle leaves when out_valid && out_ready at the
  // coming edge and no flush is pending.
  always @(negedge clk) begin
    if (rst && v2 && or2 && !fl2) begin
      if (q2.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut2_bundle: got %h, expected no bundle", ops2);
      end else begin
        chk("dut2_bundle", 64'(ops2), 64'(q2.pop_front()));
      end
    end
    if (rst && v4 && or4 && !fl4) begin
      if (q4.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut4_bundle: got %h, expected no bundle", ops4);
      end else begin
        chk("dut4_bundle", ops4, q4.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive2(1'b0, 16'h0, 1'b0); fl2 = 1'b0; or2 = 1'b0;
    drive4(1'b0, 16'h0, 1'b0); fl4 = 1'b0; or4 = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #2 rst = 1'b0;
    or2 = 1'b1;
    #1;
    chk("rst_out_valid", 64'(v2), 64'h0);
    chk("rst_ops", 64'(ops2), 64'h0);
    chk("rst_fill", 64'(fill2), 64'h0);
    chk("rst_cnt", 64'(cnt2), 64'h0);
    chk("rst_in_ready", 64'(ir2), 64'h0);
    chk("rst_ops4", ops4, 64'h0);
    or2 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Two beats, consumer stalled; bundle held five cycles
    drive2(1'b1, 16'h1234, 1'b0);
    step();
    chk("first_beat_fill", 64'(fill2), 64'h1);
    chk("first_beat_valid", 64'(v2), 64'h0);
    drive2(1'b1, 16'h5678, 1'b0);
    q2.push_back(32'h5678_1234);
    step();
    drive2(1'b1, 16'hDEAD, 1'b0);
    chk("full_valid", 64'(v2), 64'h1);
    chk("full_ops", 64'(ops2), 64'h5678_1234);
    chk("full_in_ready", 64'(ir2), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ops", 64'(ops2), 64'h5678_1234);
      chk("hold_valid", 64'(v2), 64'h1);
      chk("hold_fill", 64'(fill2), 64'h0);
    end
    drive2(1'b0, 16'h0, 1'b0);
    or2 = 1'b1;
    step();
    chk("deliver_cnt", 64'(cnt2), 64'h1);
    chk("deliver_valid", 64'(v2), 64'h0);
    or2 = 1'b0;

    // Broadcast from empty
    drive2(1'b1, 16'h3333, 1'b1);
    q2.push_back(32'h3333_3333);
    step();
    drive2(1'b0, 16'h0, 1'b0);
    chk("bcast_valid", 64'(v2), 64'h1);
    chk("bcast_ops", 64'(ops2), 64'h3333_3333);
    or2 = 1'b1;
    step();
    chk("bcast_cnt", 64'(cnt2), 64'h2);
    chk("bcast_collect_valid", 64'(v2), 64'h0);
    or2 = 1'b0;
    #1;
    chk("bcast_collect_ready", 64'(ir2), 64'h1);

    // Delivery and new beat in the same cycle
    drive2(1'b1, 16'hAAAA, 1'b0);
    step();
    drive2(1'b1, 16'hBBBB, 1'b0);
    q2.push_back(32'hBBBB_AAAA);
    step();
    drive2(1'b1, 16'hEF01, 1'b0);
    or2 = 1'b1;
    step();
    chk("overlap_cnt", 64'(cnt2), 64'h3);
    chk("overlap_fill", 64'(fill2), 64'h1);
    chk("overlap_valid", 64'(v2), 64'h0);
    chk("overlap_slot0", 64'(ops2[15:0]), 64'hEF01);
    drive2(1'b1, 16'h0102, 1'b0);
    q2.push_back(32'h0102_EF01);
    step();
    chk("overlap_full", 64'(v2), 64'h1);
    drive2(1'b0, 16'h0, 1'b0);
    step();
    chk("overlap_cnt2", 64'(cnt2), 64'h4);
    or2 = 1'b0;

    // Broadcast while delivering stays FULL
    drive2(1'b1, 16'h1111, 1'b1);
    q2.push_back(32'h1111_1111);
    step();
    or2 = 1'b1;
    drive2(1'b1, 16'h2222, 1'b1);
    q2.push_back(32'h2222_2222);
    step();
    chk("rebcast_cnt", 64'(cnt2), 64'h5);
    chk("rebcast_valid", 64'(v2), 64'h1);
    chk("rebcast_ops", 64'(ops2), 64'h2222_2222);
    drive2(1'b0, 16'h0, 1'b0);
    step();
    chk("rebcast_cnt2", 64'(cnt2), 64'h6);
    or2 = 1'b0;

    // Flush while FULL with consumer ready: no delivery counted
    drive2(1'b1, 16'h4444, 1'b1);
    step();
    drive2(1'b0, 16'h0, 1'b0);
    chk("pre_flush_valid", 64'(v2), 64'h1);
    fl2 = 1'b1;
    or2 = 1'b1;
    step();
    chk("flush_valid", 64'(v2), 64'h0);
    chk("flush_ops", 64'(ops2), 64'h0);
    chk("flush_cnt", 64'(cnt2), 64'h6);
    chk("flush_fill", 64'(fill2), 64'h0);
    fl2 = 1'b0;
    or2 = 1'b0;

    // Four-operand: two beats then broadcast fills the tail
    drive4(1'b1, 16'h000A, 1'b0);
    step();
    chk("op4_fill1", 64'(fill4), 64'h1);
    drive4(1'b1, 16'h000B, 1'b0);
    step();
    chk("op4_fill2", 64'(fill4), 64'h2);
    drive4(1'b1, 16'h000C, 1'b1);
    q4.push_back(64'h000C_000C_000B_000A);
    step();
    drive4(1'b0, 16'h0, 1'b0);
    chk("op4_valid", 64'(v4), 64'h1);
    chk("op4_ops", ops4, 64'h000C_000C_000B_000A);
    chk("op4_fill0", 64'(fill4), 64'h0);
    or4 = 1'b1;
    step();
    chk("op4_cnt", 64'(cnt4), 64'h1);
    chk("op4_after_valid", 64'(v4), 64'h0);
    or4 = 1'b0;

    // Four-operand: flush of a partial bundle
    drive4(1'b1, 16'h0077, 1'b0);
    step();
    drive4(1'b0, 16'h0, 1'b0);
    chk("op4_partial_fill", 64'(fill4), 64'h1);
    fl4 = 1'b1;
    step();
    fl4 = 1'b0;
    chk("op4_flush_fill", 64'(fill4), 64'h0);
    chk("op4_flush_ops", ops4, 64'h0);

    // Reset pulse mid-bundle: outputs clear before the next edge
    drive2(1'b1, 16'h5555, 1'b0);
    step();
    drive2(1'b0, 16'h0, 1'b0);
    chk("partial_fill", 64'(fill2), 64'h1);
    chk("partial_ops", 64'(ops2), 64'h0000_5555);
    rst = 1'b0;
    #1;
    chk("midrst_ops", 64'(ops2), 64'h0);
    chk("midrst_fill", 64'(fill2), 64'h0);
    chk("midrst_cnt", 64'(cnt2), 64'h0);
    chk("midrst_valid", 64'(v2), 64'h0);
    chk("midrst_in_ready", 64'(ir2), 64'h0);
    chk("midrst_cnt4", 64'(cnt4), 64'h0);
    #1 rst = 1'b1;

    // Seventeen back-to-back broadcast bundles: 4-bit counter wraps
    or2 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drive2(1'b1, 16'(i), 1'b1);
      q2.push_back({16'(i), 16'(i)});
      step();
    end
    chk("wrap_cnt16", 64'(cnt2), 64'h0);
    drive2(1'b0, 16'h0, 1'b0);
    step();
    chk("wrap_cnt17", 64'(cnt2), 64'h1);
    chk("wrap_valid", 64'(v2), 64'h0);
    or2 = 1'b0;

    step();
    chk("q2_drained", 64'(q2.size()), 64'h0);
    chk("q4_drained", 64'(q4.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of one operand in bits.
REQ-002 The block SHALL have parameter NUM_OPS, default 2, legal range 2..16, meaning the number of operands per bundle.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the bundle counter.
REQ-004 The block SHALL derive IDX_W = clog2(NUM_OPS) internally.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  operand beat offered.
REQ-008 in_data  input  DATA_W  operand value.
REQ-009 in_bcast  input  1  when high with in_valid, the beat fills all remaining slots.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 flush  input  1  synchronous abort of the partial or held bundle.
REQ-012 ops  output  NUM_OPS*DATA_W  bundle; slot k at bits [k*DATA_W +: DATA_W].
REQ-013 out_valid  output  1  bundle complete and held.
REQ-014 out_ready  input  1  consumer takes the bundle.
REQ-015 fill_level  output  IDX_W  index of the next slot to write.
REQ-016 bundle_cnt  output  CNT_W  number of bundles delivered.

Function
REQ-017 The block SHALL implement two states: COLLECT (out_valid=0) and FULL (out_valid=1).
REQ-018 A beat SHALL be accepted when in_valid && in_ready at a rising clock edge.
REQ-019 In COLLECT, in_ready SHALL be 1.
REQ-020 In FULL, in_ready SHALL equal out_ready, as a combinational pass-through.
REQ-021 In COLLECT, an accepted beat with in_bcast=0 SHALL write slot[fill_level] and increment fill_level.
REQ-022 When the slot written under REQ-021 is NUM_OPS-1, the block SHALL instead set fill_level to 0 and enter FULL.
REQ-023 In COLLECT, an accepted beat with in_bcast=1 SHALL write in_data to slots fill_level..NUM_OPS-1, set fill_level to 0 and enter FULL in the same edge.
REQ-024 Slots already written when in_bcast arrives SHALL keep their values.
REQ-025 Latency SHALL be one cycle: out_valid rises on the edge after the completing beat is accepted.
REQ-026 ops SHALL come directly from the slot registers, with no combinational path from in_data.
REQ-027 In FULL with out_ready=0, ops, out_valid and fill_level SHALL be held stable.
REQ-028 In FULL with out_ready=1 and no accepted beat, the block SHALL increment bundle_cnt and return to COLLECT with fill_level=0.
REQ-029 In FULL with out_ready=1 and an accepted beat with in_bcast=0, the block SHALL increment bundle_cnt, write slot 0, set fill_level to 1 and enter COLLECT.
REQ-030 In FULL with out_ready=1 and an accepted beat with in_bcast=1, the block SHALL increment bundle_cnt, write all slots and remain in FULL.
REQ-031 bundle_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-032 flush=1 SHALL have priority over every other event: next state COLLECT, fill_level=0, all slots cleared to 0.
REQ-033 A flush SHALL not increment bundle_cnt, even when out_ready=1 in FULL.
REQ-034 In COLLECT, beats with in_valid=0 SHALL change nothing.
REQ-035 in_bcast SHALL be ignored when in_valid=0.

Reset
REQ-036 rst=0 SHALL immediately, without a clock, force: state COLLECT, all slots 0, ops 0, out_valid 0, fill_level 0, bundle_cnt 0.
REQ-037 While rst=0, in_ready SHALL be 0.
REQ-038 Reset asserted mid-bundle or while FULL SHALL discard all contents.
REQ-039 After rst rises, the first beat SHALL be accepted on the first clock edge.

Verification (DATA_W=16 unless stated)
REQ-040 The bench SHALL cover: NUM_OPS=2, beats 0x1234 then 0x5678, out_ready=0 -> out_valid=1 one cycle after the second beat, ops={0x5678,0x1234}, held for 5 cycles, in_ready=0.
REQ-041 The bench SHALL cover: NUM_OPS=2, bcast beat 0x3333 from empty -> next cycle out_valid=1, ops={0x3333,0x3333}; with out_ready=1 -> bundle_cnt=1, state COLLECT.
REQ-042 The bench SHALL cover: NUM_OPS=4, beats 0xA,0xB then bcast 0xC -> ops slots {0xA,0xB,0xC,0xC}, out_valid=1.
REQ-043 The bench SHALL cover: NUM_OPS=2, FULL with out_ready=1 and in_valid beat 0xEF01 in the same cycle -> bundle_cnt increments, fill_level=1, slot0=0xEF01, out_valid=0.
REQ-044 The bench SHALL cover: flush in FULL with out_ready=1 -> out_valid=0, ops=0, bundle_cnt unchanged; rst=0 pulse mid-bundle -> outputs 0 before the next clock edge.
REQ-045 The bench SHALL cover: CNT_W=4, 17 bundles delivered -> bundle_cnt=1.
